// File: rtl/i2c_master_fsm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------------------------
// i2c_master_fsm
//
// Single-byte I2C master. One command is accepted through a start/busy/done handshake and
// turned into the bus sequence START, {addr, rw}, ACK, data byte, ACK/NACK, STOP. SCL is
// generated from a divider of the system clock (CLK_DIV clocks per quarter bit). SDA is
// open-drain: the block only ever pulls it low or releases it.
//
// Parameters
//   CLK_DIV      system clocks per SCL quarter-period (>= 2)
//
// Ports
//   clock_in     system clock, rising edge
//   reset_in     asynchronous active-low reset
//   start_in     command strobe, only looked at while idle
//   rw_in        0 = write, 1 = read (latched on acceptance)
//   addr_in      7-bit slave/RAM word address (latched on acceptance)
//   wdata_in     write data byte (latched on acceptance)
//   rdata_out    last byte successfully read
//   busy_out     high from the clock after acceptance until the done pulse
//   done_out     one-clock pulse at the end of a transaction
//   ack_err_out  slave NACKed; held until the next acceptance
//   i2c_scl      bus clock, push-pull, idles high
//   i2c_sda      bus data, open-drain (0 or Z)
// ---------------------------------------------------------------------------------------------
module i2c_master_fsm #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic       rw_in,
    input  logic [6:0] addr_in,
    input  logic [7:0] wdata_in,
    output logic [7:0] rdata_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       ack_err_out,
    output logic       i2c_scl,
    inout  wire        i2c_sda
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StStart = 4'd1;
    localparam logic [3:0] StAddr  = 4'd2;
    localparam logic [3:0] StAack  = 4'd3;
    localparam logic [3:0] StWdata = 4'd4;
    localparam logic [3:0] StWack  = 4'd5;
    localparam logic [3:0] StRdata = 4'd6;
    localparam logic [3:0] StMnack = 4'd7;
    localparam logic [3:0] StStop  = 4'd8;
    localparam logic [3:0] StDone  = 4'd9;

    logic [3:0]      state_q,   state_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      phase_q,   phase_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sr_q,      sr_d;
    logic            rw_q,      rw_d;
    logic [7:0]      wdata_q,   wdata_d;
    logic            ack_err_q, ack_err_d;
    logic [7:0]      rdata_q,   rdata_d;
    logic            busy_q;
    logic            done_q;
    logic            scl_q,     scl_d;
    logic            sda_low_q, sda_low_d;

    logic active;
    logic tick;
    logic sample;
    logic bit_end;
    logic sda_in;
    logic scl_mid;

    // The divider and phase counter only run while a bus sequence is in progress.
    assign active  = (state_q != StIdle) && (state_q != StDone);
    assign tick    = active && (div_cnt_q == DivW'(CLK_DIV - 1));
    // q2 tick: SCL has been high for a full tick, data is stable.
    assign sample  = tick && (phase_q == 2'd2);
    // q3 tick: last quarter of a bit, so the next state begins with q0.
    assign bit_end = tick && (phase_q == 2'd3);
    assign scl_mid = (phase_q == 2'd1) || (phase_q == 2'd2);
    assign sda_in  = i2c_sda;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        if (active) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                phase_d = phase_q + 2'd1;
            end
        end else begin
            div_cnt_d = '0;
            phase_d   = '0;
        end

        case (state_q)
            StIdle: begin
                if (start_in) begin
                    rw_d      = rw_in;
                    wdata_d   = wdata_in;
                    sr_d      = {addr_in, rw_in};
                    ack_err_d = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end

            StStart: begin
                if (bit_end) begin
                    state_d = StAddr;
                end
            end

            StAddr, StWdata: begin
                if (bit_end) begin
                    sr_d      = {sr_q[6:0], 1'b0};
                    // Wraps 7 -> 0 as the byte completes, ready for the next byte state.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (state_q == StAddr) ? StAack : StWack;
                    end
                end
            end

            StAack: begin
                if (sample && sda_in) begin
                    ack_err_d = 1'b1;
                end
                // ack_err_q already holds the q2 sample by the time q3 ends.
                if (bit_end) begin
                    if (ack_err_q) begin
                        state_d = StStop;
                    end else if (rw_q) begin
                        state_d = StRdata;
                    end else begin
                        sr_d    = wdata_q;
                        state_d = StWdata;
                    end
                end
            end

            StWack: begin
                if (sample && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end

            StRdata: begin
                if (sample) begin
                    sr_d = {sr_q[6:0], sda_in};
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StMnack;
                    end
                end
            end

            StMnack: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end

            StStop: begin
                if (bit_end) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                // A NACKed read never shifted in real data, so rdata keeps its old value.
                if (rw_q && !ack_err_q) begin
                    rdata_d = sr_q;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus levels per state and quarter phase
    // ------------------------------------------------------------------
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_q)
            StStart: begin
                // q0 released/high, q1-q2 SDA falls under high SCL, q3 SCL falls.
                scl_d     = (phase_q != 2'd3);
                sda_low_d = (phase_q != 2'd0);
            end
            StAddr, StWdata: begin
                scl_d     = scl_mid;
                sda_low_d = ~sr_q[7];
            end
            StAack, StWack, StRdata, StMnack: begin
                scl_d     = scl_mid;
                sda_low_d = 1'b0;
            end
            StStop: begin
                // q0 SDA low under low SCL, q1-q2 SCL high, q3 SDA released (STOP).
                scl_d     = (phase_q != 2'd0);
                sda_low_d = (phase_q != 2'd3);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            // Registered from the current state: busy rises one clock after acceptance and
            // drops in the same clock that done pulses.
            busy_q    <= active;
            done_q    <= (state_q == StDone);
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign rdata_out   = rdata_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign ack_err_out = ack_err_q;
    assign i2c_scl     = scl_q;
    assign i2c_sda     = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_fsm.sv
`timescale 1ns/1ps
module tb_i2c_master_fsm;

    localparam int unsigned CLK_DIV = 4;

    logic       clock_in = 1'b0;
    logic       reset_in;
    logic       start_in;
    logic       rw_in;
    logic [6:0] addr_in;
    logic [7:0] wdata_in;
    logic [7:0] rdata_out;
    logic       busy_out;
    logic       done_out;
    logic       ack_err_out;
    logic       scl;
    wire        sda;

    i2c_master_fsm #(.CLK_DIV(CLK_DIV)) dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .start_in    (start_in),
        .rw_in       (rw_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .rdata_out   (rdata_out),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .ack_err_out (ack_err_out),
        .i2c_scl     (scl),
        .i2c_sda     (sda)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Bus model: a slave with a small RAM, pulled-up open-drain SDA
    // ------------------------------------------------------------------
    logic       slv_low = 1'b0;
    logic       dev_present = 1'b1;
    logic [7:0] mem [128] = '{8'h15: 8'h3C, default: 8'h00};
    logic [7:0] obs_bytes [$];
    logic       obs_acks [$];
    int         stop_cnt = 0;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       in_xfer = 1'b0;
    logic       rw_rx = 1'b0;
    logic [6:0] addr_rx = '0;
    logic [7:0] shreg = '0;
    int         bit_idx = 0;
    int         byte_no = 0;

    always @(scl or sda or reset_in) begin : bus_model
        logic sv;
        sv = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (reset_in !== 1'b1) begin
            in_xfer = 1'b0;
            slv_low = 1'b0;
        end else if (scl === 1'b1 && scl_prev === 1'b1 && sv != sda_prev) begin
            if (!sv) begin
                in_xfer = 1'b1; bit_idx = 0; byte_no = 0; rw_rx = 1'b0; slv_low = 1'b0;
            end else begin
                in_xfer = 1'b0; slv_low = 1'b0; stop_cnt++;
            end
        end else if (in_xfer && scl === 1'b1 && scl_prev === 1'b0) begin
            if (bit_idx < 8) shreg = {shreg[6:0], sv};
            else if (bit_idx == 8) obs_acks.push_back(sv);
            bit_idx++;
        end else if (in_xfer && scl === 1'b0 && scl_prev === 1'b1) begin
            if (bit_idx == 8) begin
                if (byte_no == 0) begin
                    addr_rx = shreg[7:1];
                    rw_rx   = shreg[0];
                    obs_bytes.push_back(shreg);
                    slv_low = dev_present;
                end else if (!rw_rx) begin
                    mem[addr_rx] = shreg;
                    obs_bytes.push_back(shreg);
                    slv_low = 1'b1;
                end else begin
                    slv_low = 1'b0;
                end
            end else if (bit_idx == 9) begin
                bit_idx = 0;
                byte_no++;
                slv_low = (rw_rx && byte_no == 1 && dev_present) ? ~mem[addr_rx][7] : 1'b0;
            end else if (rw_rx && byte_no == 1 && bit_idx > 0) begin
                slv_low = ~mem[addr_rx][7 - bit_idx];
            end
        end
        scl_prev = scl;
        sda_prev = sv;
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } res_t;

    logic [7:0] exp_bytes [$];
    logic       exp_acks [$];
    res_t       exp_res [$];

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        @(negedge clock_in);
        rw_in    = rw;
        addr_in  = addr;
        wdata_in = wdata;
        start_in = 1'b1;
        acc_cyc  = cyc + 1;
        @(negedge clock_in);
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic pester, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock_in);
            if (pester) begin
                start_in = (i % 3 != 2);
                wdata_in = 8'($urandom);
            end
            if (done_out === 1'b1) begin
                start_in = 1'b0;
                lat = cyc - acc_cyc;
                break;
            end
        end
        start_in = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic rw, input logic [6:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rdata,
                           input logic pester);
        res_t r;
        int   lat;
        int   stops0;
        logic [7:0] ob;
        logic       oa;
        exp_bytes.push_back({addr, rw});
        exp_acks.push_back(!dev_present);
        if (dev_present && !rw) begin
            exp_bytes.push_back(wdata);
            exp_acks.push_back(1'b0);
        end
        if (dev_present && rw) exp_acks.push_back(1'b1);
        r.rdata = exp_rdata;
        r.err   = !dev_present;
        r.lat   = (dev_present ? 80 : 44) * CLK_DIV + 1;
        exp_res.push_back(r);
        stops0 = stop_cnt;

        issue(rw, addr, wdata);
        check({tag, "_busy_lag"}, busy_out, 1'b0);
        @(negedge clock_in);
        check({tag, "_busy"}, busy_out, 1'b1);
        wait_done(2000, pester, lat);

        r = exp_res.pop_front();
        check({tag, "_latency"}, lat, r.lat);
        check({tag, "_rdata"}, rdata_out, r.rdata);
        check({tag, "_ack_err"}, ack_err_out, r.err);
        check({tag, "_busy_end"}, busy_out, 1'b0);
        check({tag, "_stop"}, stop_cnt - stops0, 1);
        check({tag, "_n_bytes"}, obs_bytes.size(), exp_bytes.size());
        check({tag, "_n_acks"}, obs_acks.size(), exp_acks.size());
        while (exp_bytes.size() > 0) begin
            ob = (obs_bytes.size() > 0) ? obs_bytes.pop_front() : 8'hxx;
            check({tag, "_byte"}, ob, exp_bytes.pop_front());
        end
        while (exp_acks.size() > 0) begin
            oa = (obs_acks.size() > 0) ? obs_acks.pop_front() : 1'bx;
            check({tag, "_ack_bit"}, oa, exp_acks.pop_front());
        end
        obs_bytes.delete();
        obs_acks.delete();
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int extra_done;
        reset_in = 1'b0;
        start_in = 1'b0;
        rw_in    = 1'b0;
        addr_in  = '0;
        wdata_in = '0;
        repeat (3) @(negedge clock_in);

        check("rst_rdata", rdata_out, 8'h00);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_ack_err", ack_err_out, 1'b0);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);

        reset_in = 1'b1;
        repeat (2) @(negedge clock_in);

        // Plain write, both bytes ACKed.
        run_cmd("wr2a", 1'b0, 7'h2A, 8'hA5, 8'h00, 1'b0);
        check("wr2a_mem", mem[7'h2A], 8'hA5);

        // Read returning 0x3C, master NACKs the data byte.
        run_cmd("rd15", 1'b1, 7'h15, 8'h00, 8'h3C, 1'b0);

        // No device: address NACK, short transaction, rdata untouched.
        dev_present = 1'b0;
        run_cmd("nodev", 1'b1, 7'h40, 8'h00, 8'h3C, 1'b0);
        dev_present = 1'b1;

        // Start hammered during a write: one transaction, original wdata on the bus.
        run_cmd("pester", 1'b0, 7'h33, 8'h81, 8'h3C, 1'b1);
        extra_done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock_in);
            if (done_out === 1'b1) extra_done++;
        end
        check("pester_extra_done", extra_done, 0);
        check("pester_idle", busy_out, 1'b0);
        check("pester_mem", mem[7'h33], 8'h81);

        // Reset at tick 40 of a write (first data bit).
        issue(1'b0, 7'h2A, 8'h77);
        while (cyc < acc_cyc + 40 * CLK_DIV) @(negedge clock_in);
        check("mid_busy", busy_out, 1'b1);
        reset_in = 1'b0;
        #1;
        check("midrst_scl", scl, 1'b1);
        check("midrst_sda", sda, 1'b1);
        check("midrst_busy", busy_out, 1'b0);
        check("midrst_done", done_out, 1'b0);
        check("midrst_ack_err", ack_err_out, 1'b0);
        check("midrst_rdata", rdata_out, 8'h00);
        repeat (2) @(negedge clock_in);
        reset_in = 1'b1;
        repeat (2) @(negedge clock_in);
        obs_bytes.delete();
        obs_acks.delete();

        // Aborted write never reached the data ACK, so the old contents read back.
        run_cmd("rd2a", 1'b1, 7'h2A, 8'h00, 8'hA5, 1'b0);

        // Write then read back through the RAM model.
        run_cmd("wr10", 1'b0, 7'h10, 8'h5A, 8'hA5, 1'b0);
        run_cmd("rd10", 1'b1, 7'h10, 8'h00, 8'h5A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
